// File: rtl/instruction_fetch_unit_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_e;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: control, instruction-memory and IF/ID signals of one fetch unit
interface instruction_fetch_unit_if;
  logic Start, Stall, Flush, Redirect;
  logic [31:0] RedirectPC, IMemInstruction, IMemAddress;
  logic IFID_Valid, Halted, MisalignErr;
  logic [31:0] IFID_Instruction, IFID_PCPlus4, PC, FetchCount;
  modport master (
    input Start, Stall, Flush, Redirect, RedirectPC, IMemInstruction,
    output IMemAddress, IFID_Valid, IFID_Instruction, IFID_PCPlus4, PC, Halted, MisalignErr, FetchCount
  );
  modport slave (
    output Start, Stall, Flush, Redirect, RedirectPC, IMemInstruction,
    input IMemAddress, IFID_Valid, IFID_Instruction, IFID_PCPlus4, PC, Halted, MisalignErr, FetchCount
  );
endinterface

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; clear squashes valid/instruction and beats load
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic        valid_q,
  output logic [31:0] instr_q,
  output logic [31:0] pc4_q
);
  logic valid_d;
  logic [31:0] instr_d, pc4_d;
  always_comb begin
    valid_d = clear ? 1'b0 : load ? valid_in : valid_q;
    instr_d = clear ? NOP_WORD : load ? instr_in : instr_q;
    pc4_d = load ? pc4_in : pc4_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
      pc4_q <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, reads instruction memory and fills the IF/ID register
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT  = 32'h0000_7FFC,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input logic Clk,
  input logic Reset,
  instruction_fetch_unit_if.master bus
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, count_q, count_d, pc_plus4;
  logic misalign_q, misalign_d, seq, halt_hit, ifid_valid;
  logic [31:0] ifid_instr, ifid_pc4;
  always_comb begin
    pc_plus4 = pc_q + PC_INC;
    seq = state_q == RUN && !bus.Redirect && !bus.Stall;
    halt_hit = seq && bus.IMemInstruction == HALT_WORD;
    state_d = halt_hit ? HALTED
            : state_q == IDLE && bus.Start ? RUN
            : state_q == HALTED && bus.Redirect ? RUN
            : state_q;
    pc_d = bus.Redirect ? {bus.RedirectPC[31:2], 2'b00}
         : seq && !halt_hit ? (pc_q == PC_LIMIT ? RESET_PC : pc_plus4)
         : pc_q;
    count_d = seq && !halt_hit && !bus.Flush && count_q != '1 ? count_q + 32'd1 : count_q;
    misalign_d = bus.Redirect && bus.RedirectPC[1:0] != 2'b00;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      count_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      count_q <= count_d;
      misalign_q <= misalign_d;
    end
  end
  // a halt word is captured for visibility but never marked valid
  if_id_reg u_if_id (
    .clk      (Clk),
    .rst      (Reset),
    .load     (seq),
    .clear    (bus.Flush || bus.Redirect),
    .valid_in (!halt_hit),
    .instr_in (bus.IMemInstruction),
    .pc4_in   (pc_plus4),
    .valid_q  (ifid_valid),
    .instr_q  (ifid_instr),
    .pc4_q    (ifid_pc4)
  );
  assign bus.IMemAddress = pc_q;
  assign bus.PC = pc_q;
  assign bus.IFID_Valid = ifid_valid;
  assign bus.IFID_Instruction = ifid_instr;
  assign bus.IFID_PCPlus4 = ifid_pc4;
  assign bus.Halted = state_q == HALTED;
  assign bus.MisalignErr = misalign_q;
  assign bus.FetchCount = count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and random checks of the fetch unit against a behavioural model
module tb_instruction_fetch_unit;
  logic Clk = 1'b0;
  logic Reset;
  int tests = 0;
  int fails = 0;
  logic [31:0] mem [8192];
  // model state: mode 0 idle, 1 running, 2 halted
  int m_mode;
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic m_valid, m_mis;

  instruction_fetch_unit_if bus ();
  instruction_fetch_unit dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;
  always_comb bus.IMemInstruction = mem[bus.IMemAddress[15:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit start, input bit stall, input bit flush,
                       input bit redir, input logic [31:0] rpc);
    logic [31:0] word;
    word = mem[m_pc[15:2]];
    if (rst) begin
      m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0; m_valid = 0; m_mis = 0;
      return;
    end
    m_mis = redir && rpc[1:0] != 2'b00;
    if (redir) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_valid = 0;
      m_instr = 0;
      if (m_mode == 2) m_mode = 1;
    end else if (m_mode == 1 && !stall) begin
      m_instr = word;
      m_pc4 = m_pc + 4;
      if (word == 32'hFFFF_FFFF) begin
        m_valid = 0;
        m_mode = 2;
      end else begin
        m_valid = !flush;
        if (!flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_pc = (m_pc == 32'h7FFC) ? 32'h0 : m_pc + 4;
      end
    end
    if (m_mode == 0 && start) m_mode = 1;
    if (flush) begin
      m_valid = 0;
      m_instr = 0;
    end
  endtask

  task automatic step(input bit rst, input bit start, input bit stall, input bit flush,
                      input bit redir, input logic [31:0] rpc);
    Reset = rst; bus.Start = start; bus.Stall = stall; bus.Flush = flush;
    bus.Redirect = redir; bus.RedirectPC = rpc;
    model(rst, start, stall, flush, redir, rpc);
    @(posedge Clk);
    #1;
    chk("pc", bus.PC, m_pc);
    chk("imem_addr", bus.IMemAddress, m_pc);
    chk("ifid_valid", {31'b0, bus.IFID_Valid}, {31'b0, m_valid});
    chk("ifid_instr", bus.IFID_Instruction, m_instr);
    chk("ifid_pc4", bus.IFID_PCPlus4, m_pc4);
    chk("halted", {31'b0, bus.Halted}, {31'b0, m_mode == 2});
    chk("misalign", {31'b0, bus.MisalignErr}, {31'b0, m_mis});
    chk("fetch_count", bus.FetchCount, m_cnt);
    Reset = 0; bus.Start = 0; bus.Stall = 0; bus.Flush = 0; bus.Redirect = 0; bus.RedirectPC = 0;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0; m_valid = 0; m_mis = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 32'h123);
    chk("reset_pc", bus.PC, 32'h0);
    chk("reset_count", bus.FetchCount, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("start_no_fetch", {31'b0, bus.IFID_Valid}, 32'h0);
    idle_step();
    chk("first_instr", bus.IFID_Instruction, 32'h2008_0005);
    chk("first_pc4", bus.IFID_PCPlus4, 32'h4);
    idle_step();
    chk("second_instr", bus.IFID_Instruction, 32'h2009_0003);
    chk("second_pc4", bus.IFID_PCPlus4, 32'h8);
    chk("count_two", bus.FetchCount, 32'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    chk("stall_pc", bus.PC, 32'h8);
    chk("stall_instr", bus.IFID_Instruction, 32'h2009_0003);
    chk("stall_count", bus.FetchCount, 32'd2);
    step(0, 0, 1, 0, 1, 32'h40);
    chk("redir_stall_pc", bus.PC, 32'h40);
    chk("redir_bubble", {31'b0, bus.IFID_Valid}, 32'h0);
    idle_step();
    chk("redir_fetch", bus.IFID_Instruction, mem[16]);
    chk("redir_pc4", bus.IFID_PCPlus4, 32'h44);
    step(0, 0, 0, 0, 1, 32'h42);
    chk("misalign_pc", bus.PC, 32'h40);
    chk("misalign_hi", {31'b0, bus.MisalignErr}, 32'h1);
    idle_step();
    chk("misalign_lo", {31'b0, bus.MisalignErr}, 32'h0);
    step(0, 0, 0, 0, 1, 32'h7FFC);
    idle_step();
    chk("wrap_pc4", bus.IFID_PCPlus4, 32'h8000);
    chk("wrap_pc", bus.PC, 32'h0);
    step(0, 0, 1, 1, 0, 0);
    chk("flush_stall_pc", bus.PC, 32'h0);
    chk("flush_stall_instr", bus.IFID_Instruction, 32'h0);
    mem[4] = 32'hFFFF_FFFF;
    step(0, 0, 0, 0, 1, 32'h10);
    idle_step();
    chk("halt_valid", {31'b0, bus.IFID_Valid}, 32'h0);
    chk("halt_flag", {31'b0, bus.Halted}, 32'h1);
    for (int i = 0; i < 3; i++) idle_step();
    chk("halt_pc_held", bus.PC, 32'h10);
    step(0, 0, 0, 0, 1, 32'h0);
    chk("unhalt", {31'b0, bus.Halted}, 32'h0);
    idle_step();
    chk("unhalt_fetch", bus.IFID_Instruction, 32'h2008_0005);
    step(0, 0, 0, 0, 1, 32'h10);
    idle_step();
    chk("halt_again", {31'b0, bus.Halted}, 32'h1);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_halt_pc", bus.PC, 32'h0);
    chk("reset_halt_flag", {31'b0, bus.Halted}, 32'h0);
    for (int i = 0; i < 40; i++) mem[$urandom_range(0, 8191)] = 32'hFFFF_FFFF;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 32'h7FFF));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
